// File: rtl/init_deal_ctrl.sv
// Initial-deal controller: draws DEAL_COUNT random cards from the shared deck,
// announces each draw to the peer board, then hands the turn over.
module init_deal_ctrl #(
  parameter int PLAYER     = 0,
  parameter int DEAL_COUNT = 14
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_interboard_rst,
  input  logic         i_start_game,
  input  logic         i_send_ready,
  input  logic         i_interboard_en,
  input  logic [3:0]   i_interboard_msg_type,
  input  logic [105:0] i_available_card,
  output logic         o_ctrl_en,
  output logic [3:0]   o_ctrl_msg_type,
  output logic [5:0]   o_ctrl_card,
  output logic [4:0]   o_ctrl_block_x,
  output logic         o_deal_busy,
  output logic         o_init_done,
  output logic         o_deal_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_PEER, S_SCAN, S_SEND, S_WAIT_BUSY,
    S_WAIT_RDY, S_PASS, S_WAIT_TURN, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0] MSG_DRAW = 4'd5;
  localparam logic [3:0] MSG_TURN = 4'd6;
  localparam logic [4:0] DC       = 5'(DEAL_COUNT);
  localparam bit         P1       = (PLAYER != 0);

  state_t         r_state;
  logic [6:0]     r_lfsr;
  logic [6:0]     r_ptr;
  logic [6:0]     r_scan_cnt;
  logic [4:0]     r_cnt;
  logic [105:0]   r_claimed;
  logic [5:0]     r_card_pend;
  logic           r_ctrl_en;
  logic [3:0]     r_msg;
  logic [5:0]     r_card;
  logic [4:0]     r_bx;
  logic           r_busy;
  logic           r_done;
  logic           r_err;

  logic [6:0]     w_ptr_init;
  logic [6:0]     w_ptr_next;
  logic           w_elig;
  logic [5:0]     w_card;
  logic [4:0]     w_cnt_inc;
  logic           w_peer_turn;

  // Free-running; only the board reset reseeds it so the peer abort keeps randomness.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= 7'h5A;
    else       r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
  end

  assign w_ptr_init  = (r_lfsr >= 7'd106) ? r_lfsr - 7'd106 : r_lfsr;
  assign w_ptr_next  = (r_ptr == 7'd105) ? 7'd0 : r_ptr + 7'd1;
  assign w_elig      = i_available_card[r_ptr] & ~r_claimed[r_ptr];
  assign w_card      = 6'((r_ptr >= 7'd54) ? r_ptr - 7'd54 : r_ptr);
  assign w_cnt_inc   = (r_cnt == DC) ? r_cnt : r_cnt + 5'd1;
  assign w_peer_turn = i_interboard_en && (i_interboard_msg_type == MSG_TURN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_scan_cnt  <= '0;
      r_cnt       <= '0;
      r_claimed   <= '0;
      r_card_pend <= '0;
      r_ctrl_en   <= 1'b0;
      r_msg       <= '0;
      r_card      <= '0;
      r_bx        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (i_interboard_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_scan_cnt  <= '0;
      r_cnt       <= '0;
      r_claimed   <= '0;
      r_card_pend <= '0;
      r_ctrl_en   <= 1'b0;
      r_msg       <= '0;
      r_card      <= '0;
      r_bx        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ctrl_en <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start_game) begin
          r_claimed <= '0;
          r_busy    <= 1'b1;
          if (P1) begin
            r_state <= S_WAIT_PEER;
          end else begin
            r_state    <= S_SCAN;
            r_ptr      <= w_ptr_init;
            r_scan_cnt <= '0;
          end
        end
        S_WAIT_PEER: if (w_peer_turn) begin
          r_state    <= S_SCAN;
          r_ptr      <= w_ptr_init;
          r_scan_cnt <= '0;
        end
        S_SCAN: begin
          r_ptr <= w_ptr_next;
          if (w_elig) begin
            r_claimed[r_ptr] <= 1'b1;
            r_card_pend      <= w_card;
            // Ready already up: strobe straight from the scan for 1-cycle latency.
            if (i_send_ready) begin
              r_ctrl_en <= 1'b1;
              r_msg     <= MSG_DRAW;
              r_card    <= w_card;
              r_bx      <= r_cnt;
              r_state   <= S_WAIT_BUSY;
            end else begin
              r_state <= S_SEND;
            end
          end else if (r_scan_cnt == 7'd105) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_scan_cnt <= r_scan_cnt + 7'd1;
          end
        end
        S_SEND: if (i_send_ready) begin
          r_ctrl_en <= 1'b1;
          r_msg     <= MSG_DRAW;
          r_card    <= r_card_pend;
          r_bx      <= r_cnt;
          r_state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: if (!i_send_ready) r_state <= S_WAIT_RDY;
        S_WAIT_RDY: if (i_send_ready) begin
          r_cnt <= w_cnt_inc;
          // Count already saturated means this handshake was the turn pass.
          if (r_cnt == DC) begin
            if (P1) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WAIT_TURN;
            end
          end else if (w_cnt_inc < DC) begin
            r_state    <= S_SCAN;
            r_ptr      <= w_ptr_init;
            r_scan_cnt <= '0;
          end else begin
            r_state <= S_PASS;
          end
        end
        S_PASS: if (i_send_ready) begin
          r_ctrl_en <= 1'b1;
          r_msg     <= MSG_TURN;
          r_state   <= S_WAIT_BUSY;
        end
        S_WAIT_TURN: if (w_peer_turn) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_ctrl_en       = r_ctrl_en;
  assign o_ctrl_msg_type = r_msg;
  assign o_ctrl_card     = r_card;
  assign o_ctrl_block_x  = r_bx;
  assign o_deal_busy     = r_busy;
  assign o_init_done     = r_done;
  assign o_deal_err      = r_err;

endmodule

// File: tb/tb_init_deal_ctrl.sv
// Scoreboard bench for init_deal_ctrl: one instance per board role, expected
// strobes queued by the stimulus and popped by a negedge monitor.
module tb_init_deal_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ib_rst = 1'b0;
  logic [3:0]   imsg = '0;
  logic [105:0] avail;
  logic         start [2];
  logic         ibe   [2];
  logic         sr    [2];
  logic         en    [2];
  logic [3:0]   msg   [2];
  logic [5:0]   card  [2];
  logic [4:0]   bx    [2];
  logic         busy  [2];
  logic         done  [2];
  logic         err   [2];

  always #5 clk = ~clk;

  init_deal_ctrl #(.PLAYER(0), .DEAL_COUNT(14)) u0 (
    .i_clk(clk), .i_rst(rst), .i_interboard_rst(ib_rst), .i_start_game(start[0]),
    .i_send_ready(sr[0]), .i_interboard_en(ibe[0]), .i_interboard_msg_type(imsg),
    .i_available_card(avail), .o_ctrl_en(en[0]), .o_ctrl_msg_type(msg[0]),
    .o_ctrl_card(card[0]), .o_ctrl_block_x(bx[0]), .o_deal_busy(busy[0]),
    .o_init_done(done[0]), .o_deal_err(err[0]));

  init_deal_ctrl #(.PLAYER(1), .DEAL_COUNT(14)) u1 (
    .i_clk(clk), .i_rst(rst), .i_interboard_rst(ib_rst), .i_start_game(start[1]),
    .i_send_ready(sr[1]), .i_interboard_en(ibe[1]), .i_interboard_msg_type(imsg),
    .i_available_card(avail), .o_ctrl_en(en[1]), .o_ctrl_msg_type(msg[1]),
    .o_ctrl_card(card[1]), .o_ctrl_block_x(bx[1]), .o_deal_busy(busy[1]),
    .o_init_done(done[1]), .o_deal_err(err[1]));

  typedef struct {
    int         inst;
    logic [3:0] msg;
    logic [5:0] card;
    logic [4:0] bx;
    bit         care_card;
    bit         care_bx;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_strobe [2] = '{0, 0};
  int   strobe_cyc [2] = '{0, 0};
  int   tx_cnt [2] = '{0, 0};
  int   stop_at [2] = '{0, 0};
  bit   tx_hold [2] = '{1'b1, 1'b0};
  int   face_cnt [54];
  int   cyc_no = 0;
  logic [6:0] m_lfsr;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Reference LFSR, used only to choose when to start the wrap/exhaustion case.
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 7'h5A;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};

  task automatic check(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Transmitter model: drops ready on each strobe, raises it two cycles later.
  for (genvar g = 0; g < 2; g++) begin : g_tx
    int low_left = 0;
    always @(negedge clk) begin
      if (en[g]) begin
        tx_cnt[g]++;
        low_left = 2;
      end else if (low_left > 0) begin
        low_left--;
      end
      sr[g] = !tx_hold[g] && (low_left == 0) && (stop_at[g] == 0 || tx_cnt[g] != stop_at[g]);
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (en[i]) begin
        n_strobe[i]++;
        strobe_cyc[i] = cyc_no;
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe u%0d: got msg %0d block_x %0d, required no strobe", i, msg[i], bx[i]);
        end else begin
          e = sbq.pop_front();
          check($sformatf("strobe_inst"), i, e.inst);
          check($sformatf("msg_type_u%0d", i), int'(msg[i]), int'(e.msg));
          if (e.care_bx)   check($sformatf("block_x_u%0d", i), int'(bx[i]), int'(e.bx));
          if (e.care_card) check($sformatf("card_u%0d", i), int'(card[i]), int'(e.card));
          if (msg[i] == 4'd5) begin
            check($sformatf("card_range_u%0d", i), int'(card[i] < 6'd54), 1);
            if (card[i] < 6'd54) begin
              face_cnt[card[i]]++;
              check($sformatf("face_used_at_most_twice_u%0d", i), int'(face_cnt[card[i]] > 2), 0);
            end
          end
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int outs(int i);
    return int'({en[i], msg[i], card[i], bx[i], busy[i], done[i], err[i]});
  endfunction

  task automatic clr_faces();
    foreach (face_cnt[j]) face_cnt[j] = 0;
  endtask

  task automatic push_draws(int i, int n);
    for (int b = 0; b < n; b++) sbq.push_back('{i, 4'd5, 6'd0, 5'(b), 1'b0, 1'b1});
  endtask

  task automatic push_deal(int i);
    push_draws(i, 14);
    sbq.push_back('{i, 4'd6, 6'd0, 5'd0, 1'b0, 1'b0});
  endtask

  task automatic pulse_start(int i);
    start[i] = 1'b1;
    cyc(1);
    start[i] = 1'b0;
  endtask

  task automatic peer_msg(int i, logic [3:0] t);
    imsg   = t;
    ibe[i] = 1'b1;
    cyc(1);
    ibe[i] = 1'b0;
    imsg   = '0;
  endtask

  task automatic wait_strobes(int i, int n, int budget);
    int k = 0;
    while (n_strobe[i] < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    cyc(1);
    check($sformatf("strobe_count_u%0d", i), n_strobe[i], n);
  endtask

  initial begin
    int n0;
    int k;
    start = '{1'b0, 1'b0};
    ibe   = '{1'b0, 1'b0};
    avail = '1;
    clr_faces();
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("reset_outputs_u0", outs(0), 0);
    check("reset_outputs_u1", outs(1), 0);

    // Player 0 full deal; ready held low for 50 cycles at the first send.
    push_deal(0);
    pulse_start(0);
    n0 = n_strobe[0];
    cyc(50);
    check("no_strobe_while_not_ready", n_strobe[0] - n0, 0);
    check("busy_while_send_waits", int'(busy[0]), 1);
    tx_hold[0] = 1'b0;
    wait_strobes(0, n0 + 15, 400);
    cyc(5);
    check("u0_not_done_before_peer_turn", int'(done[0]), 0);
    check("u0_busy_in_wait_turn", int'(busy[0]), 1);
    peer_msg(0, 4'd6);
    check("u0_init_done", int'(done[0]), 1);
    check("u0_idle_busy_after_done", int'(busy[0]), 0);

    // Peer abort in the middle of the deal, then a clean restart.
    ib_rst = 1'b1;
    cyc(1);
    ib_rst = 1'b0;
    check("ibrst_outputs_u0", outs(0), 0);
    clr_faces();
    n0 = n_strobe[0];
    stop_at[0] = tx_cnt[0] + 8;
    push_draws(0, 8);
    pulse_start(0);
    wait_strobes(0, n0 + 8, 200);
    cyc(3);
    check("busy_in_wait_rdy", int'(busy[0]), 1);
    ib_rst = 1'b1;
    cyc(1);
    ib_rst = 1'b0;
    check("abort_outputs_u0", outs(0), 0);
    stop_at[0] = 0;
    cyc(2);
    clr_faces();
    push_deal(0);
    pulse_start(0);
    wait_strobes(0, n0 + 8 + 15, 400);

    // Player 1: waits for the peer turn message, finishes on its own pass.
    clr_faces();
    pulse_start(1);
    cyc(3);
    peer_msg(1, 4'd3);
    cyc(20);
    check("u1_no_strobe_before_turn", n_strobe[1], 0);
    check("u1_busy_waiting_peer", int'(busy[1]), 1);
    push_deal(1);
    peer_msg(1, 4'd6);
    wait_strobes(1, 15, 400);
    cyc(6);
    check("u1_init_done", int'(done[1]), 1);
    check("u1_busy_after_done", int'(busy[1]), 0);

    // Wrap and deck exhaustion: only indices 105 and 0 exist, scan starts at 104.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    avail = '0;
    avail[105] = 1'b1;
    avail[0]   = 1'b1;
    clr_faces();
    sbq.push_back('{0, 4'd5, 6'd51, 5'd0, 1'b1, 1'b1});
    sbq.push_back('{0, 4'd5, 6'd0,  5'd1, 1'b1, 1'b1});
    k = 0;
    while (m_lfsr != 7'd104 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("lfsr_reaches_104", int'(m_lfsr), 104);
    n0 = n_strobe[0];
    pulse_start(0);
    wait_strobes(0, n0 + 2, 200);
    cyc(30);
    pulse_start(0);
    k = 0;
    while (!err[0] && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("deal_err_set", int'(err[0]), 1);
    check("err_after_106_scans", cyc_no - strobe_cyc[0], 109);
    check("err_busy_low", int'(busy[0]), 0);
    check("err_no_done", int'(done[0]), 0);
    check("held_msg_type", int'(msg[0]), 5);
    check("held_block_x", int'(bx[0]), 1);
    cyc(5);
    check("err_holds", int'(err[0]), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_rst_outputs_u0", outs(0), 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
